hit_detect: RTL and testbench
=============================

Name: hit_detect

Overview:
- Parametrised successor to the single-bit space/work registration stage in the whack-a-mole datapath.
- Synchronises and debounces the raw space (hammer) button, then detects one press per physical push.
- Compares the cursor position against an N-wide active-mole vector and emits one-cycle hit/miss pulses with the struck index.
- Keeps saturating hit and miss counters that feed the score display.

Parameters:
- N_MOLES, 9: number of mole channels (width of mole_active).
- IDX_W, 4: width of cursor and hit_idx; must satisfy 2^IDX_W >= N_MOLES.
- DEBOUNCE, 4: consecutive synchronised-stable cycles required for press or release; must be >= 1.
- CNT_W, 8: width of hit_count and miss_count.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- space, input, 1: raw asynchronous button, active high.
- game_en, input, 1: when low, accepted presses produce no pulse and no count.
- clear_scores, input, 1: synchronous clear of both counters.
- mole_active, input, N_MOLES: bit i high means mole i is currently up.
- cursor, input, IDX_W: index of the hole under the hammer.
- work, output, 1: debounced button level, high from entry to EVAL until release is debounced.
- hit, output, 1: one-cycle pulse on a successful strike.
- miss, output, 1: one-cycle pulse on an unsuccessful strike.
- hit_idx, output, IDX_W: cursor value captured at the last hit; holds until the next hit.
- hit_count, output, CNT_W: saturating count of hits.
- miss_count, output, CNT_W: saturating count of misses.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, both sync flops 0, debounce counter 0, state IDLE. Reset asserted mid-press aborts the press with no pulse.
- Synchroniser: 2-flop chain on space produces space_s; no other logic samples space directly.
- FSM states and transitions:
  - IDLE: if space_s = 1, go to DB_PRESS with cnt = 0.
  - DB_PRESS: if space_s = 0, go to IDLE. Otherwise, if cnt = DEBOUNCE-1, go to EVAL; else increment cnt.
  - EVAL: single cycle. Sample mole_active and cursor. Go to HELD and register the outputs for that edge.
  - HELD: if space_s = 0, go to DB_REL with cnt = 0.
  - DB_REL: if space_s = 1, go to HELD. Otherwise, if cnt = DEBOUNCE-1, go to IDLE; else increment cnt.
- Strike evaluation, on the edge leaving EVAL:
  - Hit: cursor < N_MOLES and mole_active[cursor] = 1. Set hit = 1, hit_idx = cursor, hit_count += 1.
  - Miss: all other cases, including cursor >= N_MOLES. Set miss = 1, miss_count += 1.
  - game_en = 0 at EVAL: no pulse, no count change; FSM still moves to HELD.
- hit and miss are high for exactly one cycle and are never high together.
- work is registered: goes to 1 on the edge entering EVAL and to 0 on the edge entering IDLE from DB_REL.
- Latency: with space stable high and sampled first at edge E0, hit/miss is high in the cycle after edge E0+DEBOUNCE+3. With default DEBOUNCE = 4 that is edge E7.
- Only one strike per push: holding the button never re-fires. Bounces shorter than DEBOUNCE cycles in either state are absorbed.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clear_scores coincident with a strike: the counter clears to 0 (clear wins); the hit/miss pulse still fires and hit_idx still updates.
- mole_active and cursor are don't-care outside EVAL.

Test Plan:
- Clean press: space held high 20 cycles, mole_active = 9'h010, cursor = 4, DEBOUNCE = 4 -> hit pulse one cycle at edge E7, hit_idx = 4, hit_count = 1, miss stays 0, work high until the release is debounced.
- Miss and out-of-range: mole_active = 9'h010, cursor = 3 -> miss pulse, miss_count = 1. Then cursor = 12 -> second miss, miss_count = 2.
- Bounce rejection:
  - space pulses of 1-3 cycles -> no pulse, work stays 0.
  - Held press with a 2-cycle low glitch in HELD -> no second pulse, work stays 1.
- Saturation and clear: CNT_W = 2, 5 hits -> hit_count holds at 3. Assert clear_scores in the same cycle as a hit -> hit_count = 0, hit pulse still seen.
- game_en = 0 during a full press -> no hit/miss, counts unchanged. Next press with game_en = 1 scores normally.
- Reset mid-operation: rst_n low during DB_PRESS and again in HELD -> all outputs 0 immediately. After release with space still held, exactly one strike occurs after DEBOUNCE+4 cycles.

Source files
------------

// File: rtl/hit_detect.sv
// Hammer-button strike detector: synchronises and debounces the space button, scores one
// strike per push against the active-mole vector, and keeps saturating hit/miss counters.
module hit_detect #(
    parameter int N_MOLES  = 9,
    parameter int IDX_W    = 4,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               space,
    input  logic               game_en,
    input  logic               clear_scores,
    input  logic [N_MOLES-1:0] mole_active,
    input  logic [IDX_W-1:0]   cursor,
    output logic               work,
    output logic               hit,
    output logic               miss,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    // state    | meaning
    // IDLE     | button released, waiting for space_s
    // DB_PRESS | space_s high, counting stable cycles before accepting the press
    // EVAL     | single cycle: strike scored on the edge leaving this state
    // HELD     | press accepted, waiting for space_s to drop
    // DB_REL   | space_s low, counting stable cycles before accepting the release

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        EVAL     = 3'd2,
        HELD     = 3'd3,
        DB_REL   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [DB_W-1:0] cnt;
    logic [DB_W-1:0] cnt_nx;
    logic            sync_q1;
    logic            space_s;
    logic            work_nx;
    logic            mole_at;
    logic            strike_hit;
    logic            strike_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            space_s <= 1'b0;
        end else begin
            sync_q1 <= space;
            space_s <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            work  <= work_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (space_s) begin
                    state_nx = DB_PRESS;
                    cnt_nx   = '0;
                end
            end
            DB_PRESS: begin
                if (!space_s) begin
                    state_nx = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nx = EVAL;
                end else begin
                    cnt_nx = cnt + DB_W'(1);
                end
            end
            EVAL: begin
                state_nx = HELD;
            end
            HELD: begin
                if (!space_s) begin
                    state_nx = DB_REL;
                    cnt_nx   = '0;
                end
            end
            DB_REL: begin
                if (space_s) begin
                    state_nx = HELD;
                end else if (cnt == DB_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + DB_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        work_nx = work;
        if (state_nx == EVAL) begin
            work_nx = 1'b1;
        end else if ((state == DB_REL) && (state_nx == IDLE)) begin
            work_nx = 1'b0;
        end
    end

    // Explicit match loop so an out-of-range cursor never indexes past mole_active.
    always_comb begin
        mole_at = 1'b0;
        for (int i = 0; i < N_MOLES; i++) begin
            if (cursor == IDX_W'(i)) begin
                mole_at = mole_active[i];
            end
        end
    end

    assign strike_hit  = (state == EVAL) && game_en && mole_at;
    assign strike_miss = (state == EVAL) && game_en && !mole_at;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit     <= 1'b0;
            miss    <= 1'b0;
            hit_idx <= '0;
        end else begin
            hit  <= strike_hit;
            miss <= strike_miss;
            if (strike_hit) begin
                hit_idx <= cursor;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (clear_scores) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (strike_hit && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (strike_miss && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hit_detect.sv
// Directed bench for hit_detect: a default-width instance and a 2-bit-counter instance share
// stimulus; expected strikes are queued when a press is driven and popped when a pulse appears.
module tb_hit_detect;

    localparam int DB = 4;

    typedef struct {
        logic       is_hit;
        logic [3:0] idx;
        int         hc;
        int         mc;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       space;
    logic       game_en;
    logic       clear_scores;
    logic [8:0] mole_active;
    logic [3:0] cursor;

    logic       work, hit, miss;
    logic [3:0] hit_idx;
    logic [7:0] hit_count, miss_count;
    logic       s_work, s_hit, s_miss;
    logic [3:0] s_idx;
    logic [1:0] s_hc, s_mc;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_hits = 0;
    int   m_misses = 0;
    logic [3:0] m_idx = '0;
    exp_t sb[$];
    exp_t mon_e;

    hit_detect #(.N_MOLES(9), .IDX_W(4), .DEBOUNCE(DB), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .space(space), .game_en(game_en),
        .clear_scores(clear_scores), .mole_active(mole_active), .cursor(cursor),
        .work(work), .hit(hit), .miss(miss), .hit_idx(hit_idx),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    hit_detect #(.N_MOLES(9), .IDX_W(4), .DEBOUNCE(DB), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .space(space), .game_en(game_en),
        .clear_scores(clear_scores), .mole_active(mole_active), .cursor(cursor),
        .work(s_work), .hit(s_hit), .miss(s_miss), .hit_idx(s_idx),
        .hit_count(s_hc), .miss_count(s_mc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int satv(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model of one strike, queued at the negedge where space is raised (or reset released).
    task automatic push_strike(input bit clr);
        exp_t e;
        if (!game_en) return;
        e.is_hit = 1'b0;
        if (cursor < 4'd9) e.is_hit = mole_active[cursor];
        if (e.is_hit) begin
            m_hits++;
            m_idx = cursor;
        end else begin
            m_misses++;
        end
        if (clr) begin
            m_hits   = 0;
            m_misses = 0;
        end
        e.idx = m_idx;
        e.hc  = m_hits;
        e.mc  = m_misses;
        e.due = cyc + DB + 4;
        sb.push_back(e);
    endtask

    task automatic press(input logic [3:0] cur, input logic [8:0] moles, input int hold,
                         input bit clr);
        cursor      = cur;
        mole_active = moles;
        space       = 1'b1;
        push_strike(clr);
        if (clr) begin
            tick(DB + 3);
            clear_scores = 1'b1;
            tick(1);
            clear_scores = 1'b0;
            tick(hold - DB - 4);
        end else begin
            tick(hold);
        end
        check("work_while_held", work, 1);
        space = 1'b0;
        tick(DB + 6);
        check("work_after_release", work, 0);
        check("strike_consumed", sb.size(), 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hit_count"}, hit_count, satv(m_hits, 8));
        check({tag, "_miss_count"}, miss_count, satv(m_misses, 8));
        check({tag, "_sat_hit_count"}, s_hc, satv(m_hits, 2));
        check({tag, "_sat_miss_count"}, s_mc, satv(m_misses, 2));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_work"}, work, 0);
        check({tag, "_hit"}, hit, 0);
        check({tag, "_miss"}, miss, 0);
        check({tag, "_hit_idx"}, hit_idx, 0);
        check({tag, "_hit_count"}, hit_count, 0);
        check({tag, "_miss_count"}, miss_count, 0);
        check({tag, "_sat_counts"}, {s_hc, s_mc}, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (hit || miss || s_hit || s_miss)) begin
            check("hit_miss_exclusive", hit & miss, 0);
            check("sat_pulses_match", {s_hit, s_miss}, {hit, miss});
            check("pulse_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("pulse_latency", cyc, mon_e.due);
                check("pulse_is_hit", hit, mon_e.is_hit);
                check("pulse_is_miss", miss, !mon_e.is_hit);
                check("hit_idx", hit_idx, mon_e.idx);
                check("hit_count", hit_count, satv(mon_e.hc, 8));
                check("miss_count", miss_count, satv(mon_e.mc, 8));
                check("sat_hit_count", s_hc, satv(mon_e.hc, 2));
                check("sat_miss_count", s_mc, satv(mon_e.mc, 2));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        space        = 1'b0;
        game_en      = 1'b1;
        clear_scores = 1'b0;
        mole_active  = '0;
        cursor       = '0;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(3);

        // clean hit, then in-range miss and out-of-range miss
        press(4'd4, 9'h010, 20, 1'b0);
        check("hit_idx_hold_1", hit_idx, 4);
        press(4'd3, 9'h010, 12, 1'b0);
        press(4'd12, 9'h010, 12, 1'b0);
        check("hit_idx_hold_2", hit_idx, 4);
        check_counts("after_misses");

        // short bounces never reach EVAL
        for (int w = 1; w <= DB - 1; w++) begin
            space = 1'b1;
            tick(w);
            space = 1'b0;
            repeat (10) begin
                tick(1);
                check("bounce_work", work, 0);
            end
        end
        check_counts("after_bounce");

        // 2-cycle low glitch while held: no re-fire, work stays high
        cursor      = 4'd0;
        mole_active = 9'h001;
        space       = 1'b1;
        push_strike(1'b0);
        tick(12);
        space = 1'b0;
        tick(2);
        space = 1'b1;
        repeat (10) begin
            tick(1);
            check("glitch_work", work, 1);
        end
        space = 1'b0;
        tick(DB + 6);
        check("glitch_work_released", work, 0);
        check("glitch_single_strike", sb.size(), 0);

        // disabled game: press accepted but unscored
        game_en = 1'b0;
        press(4'd4, 9'h010, 12, 1'b0);
        check_counts("game_disabled");
        game_en = 1'b1;
        press(4'd8, 9'h100, 12, 1'b0);
        check("hit_idx_8", hit_idx, 8);

        // saturation of the 2-bit instance
        for (int k = 0; k < 5; k++) begin
            press(4'(k + 1), 9'h1FE, 12, 1'b0);
        end
        check_counts("saturated");

        // clear coincident with a strike wins on the counter, pulse still fires
        press(4'd6, 9'h040, 12, 1'b1);
        check_counts("clear_at_strike");
        check("hit_idx_after_clear", hit_idx, 6);
        press(4'd5, 9'h000, 12, 1'b0);
        clear_scores = 1'b1;
        tick(1);
        clear_scores = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        check_counts("standalone_clear");

        // reset during DB_PRESS, then during HELD, with space held throughout
        cursor      = 4'd2;
        mole_active = 9'h004;
        space       = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_db_press");
        m_hits   = 0;
        m_misses = 0;
        m_idx    = '0;
        tick(2);
        rst_n = 1'b1;
        push_strike(1'b0);
        tick(12);
        check("reset_strike_consumed", sb.size(), 0);
        check("reset_strike_idx", hit_idx, 2);
        check("work_held_after_reset", work, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_held");
        m_hits   = 0;
        m_misses = 0;
        m_idx    = '0;
        tick(2);
        rst_n = 1'b1;
        push_strike(1'b0);
        tick(12);
        space = 1'b0;
        tick(DB + 6);
        check("reset_held_work_released", work, 0);
        check_counts("after_reset_held");

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
